// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks register-file addresses 0..NUM_REGS-1 and streams
// each captured value out over valid/ready with its index and a last flag.
module regfile_dump_reader #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  last_q, last_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        // Snapshot the register as it is in this cycle; later writes do not alter the word.
        data_d  = rf_data;
        index_d = cnt_q;
        last_d  = (cnt_q == LastAddr);
        state_d = StSend;
      end
      StSend: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign rf_addr   = cnt_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign out_valid = (state_q == StSend);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the integer register file. On a start pulse it walks every register address from 0 to NUM_REGS-1 through one register-file read port, captures each value, and streams it out over a valid/ready interface with its index and a last flag. It sits beside the register file on the debug/test path and is the read-side counterpart to the pipeline's writeback port.

## Interface
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of registers scanned; NUM_REGS <= 2^ADDR_WIDTH and NUM_REGS >= 1

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE
- rf_addr  out  ADDR_WIDTH  address to the register-file read port
- rf_data  in  DATA_WIDTH  combinational read data returned for rf_addr
- out_valid  out  1  out_data/out_index/out_last are valid
- out_ready  in  1  consumer accepts the word when high with out_valid
- out_data  out  DATA_WIDTH  captured register value
- out_index  out  ADDR_WIDTH  register number of out_data
- out_last  out  1  high with the word for register NUM_REGS-1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: busy=0, out_valid=0. start=1 -> READ, internal addr counter <= 0.
- READ: rf_addr = counter; at clock edge capture out_data <= rf_data, out_index <= counter, out_last <= (counter == NUM_REGS-1); -> SEND.
- SEND: out_valid=1. out_ready=0 -> stay; out_data, out_index, out_last held stable. out_ready=1 and out_last=0 -> counter <= counter+1, -> READ. out_ready=1 and out_last=1 -> DONE.
- DONE: done=1 for exactly this cycle, busy=1, out_valid=0; -> IDLE unconditionally.
- rf_addr is a registered output equal to the counter in all states. It holds its last value outside a dump and returns to 0 at reset and on each new start.
- Register 0 is dumped like any other; the register file supplies 0 for it, and the block performs no special-casing.
- Counter width is ADDR_WIDTH. It never increments past NUM_REGS-1, so there is no wrap-around.
- start while busy=1 is ignored and does not restart or queue a dump.
- Register-file writes during a dump: each word reflects the register contents at its READ cycle.
- Reset (any state, including mid-SEND): next cycle is IDLE; all outputs 0; counter 0; no done pulse.

## Timing
- Reset values: rf_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.
- start sampled high at edge N -> READ during cycle N+1 -> out_valid=1 from cycle N+2.
- With out_ready tied high, one word every 2 cycles. A full dump with start at edge N: last word accepted at the edge ending cycle N+2*NUM_REGS, done high in cycle N+2*NUM_REGS+1, IDLE and busy=0 in the following cycle.
- out_valid, once high, stays high until accepted (no withdrawal). Data is stable throughout.
- All outputs are registered or decoded from state only. There is no combinational path from out_ready or start to any output.
- start may be reasserted in the cycle after done; it is accepted because the block is in IDLE.

## Test plan
- Preload regs 1..31 with 0x1000_0000_0000_0000+i. Start, out_ready=1 -> 32 words in index order 0..31, word0=0, wordi=0x1000_0000_0000_0000+i, out_last only on index 31, done pulses once, total 65 cycles from start to done.
- Backpressure: deassert out_ready for 5 cycles on index 7 -> out_valid stays high, out_data/out_index stay 7-word unchanged, no index skipped or duplicated.
- start pulsed during SEND of index 3 -> ignored; dump continues 4..31 and a single done pulse results.
- Reset asserted while holding index 12 -> next cycle all outputs 0, busy=0. A new start then dumps from index 0.
- Write reg 20 := 0xDEAD_BEEF_0000_0001 while the dump sits at index 10 -> index 20 reports the new value. With the write at index 25 instead, index 20 reports the old value.
- NUM_REGS=4 instance: exactly 4 words, out_last on index 3, done 9 cycles after start.
